// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// FSM states, write-entry record and the stored preset tables.
package pll_reconfig_pkg;

    localparam logic [5:0] ADDR_MODE   = 6'd0;
    localparam logic [5:0] ADDR_STATUS = 6'd1;
    localparam logic [5:0] ADDR_START  = 6'd2;
    localparam logic [5:0] ADDR_N      = 6'd3;
    localparam logic [5:0] ADDR_M      = 6'd4;
    localparam logic [5:0] ADDR_C      = 6'd5;
    localparam logic [5:0] ADDR_DPS    = 6'd6;
    localparam logic [5:0] ADDR_MFRAC  = 6'd7;

    localparam int ROM_IDX_W = 3;

    typedef enum logic [2:0] {
        S_IDLE, S_WR_MODE, S_WR_REGS, S_WR_START, S_WAIT_LOCK, S_DONE, S_ERROR
    } state_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [31:0] data;
    } entry_t;

    localparam logic [7:0]  N_DIV  [8] = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    localparam logic [7:0]  M_MUL  [8] = '{8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13};
    localparam logic [31:0] M_FRAC [8] = '{32'h0000_0000, 32'h1000_0000, 32'h2000_0000, 32'h3000_0000,
                                          32'h4000_0000, 32'h5000_0000, 32'h6000_0000, 32'h7000_0000};
    localparam logic [7:0]  C_BASE [8] = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};

    function automatic logic [31:0] div_word(input logic [7:0] hi, input logic [7:0] lo);
        return {16'h0000, hi, lo};
    endfunction

    // C-counter words carry the counter select in data[22:18].
    function automatic logic [31:0] cnt_word(input logic [4:0] sel, input logic [7:0] hi,
                                             input logic [7:0] lo);
        return {9'd0, sel, 2'b00, hi, lo};
    endfunction

    // Write order per preset: N, M, M-fraction, then C0..C4.
    function automatic entry_t preset_entry(input logic [ROM_IDX_W-1:0] p,
                                            input logic [ROM_IDX_W-1:0] s);
        logic [7:0] d;
        d = C_BASE[p] + 8'(s - 3'd3);
        case (s)
            3'd0:    return '{addr: ADDR_N,     data: div_word(N_DIV[p], N_DIV[p])};
            3'd1:    return '{addr: ADDR_M,     data: div_word(M_MUL[p], M_MUL[p])};
            3'd2:    return '{addr: ADDR_MFRAC, data: M_FRAC[p]};
            default: return '{addr: ADDR_C,     data: cnt_word(5'(s - 3'd3), d, d)};
        endcase
    endfunction

endpackage

// File: rtl/pll_reconfig_rom.sv
// Combinational preset lookup: (preset, step) -> {address, data} register write.
module pll_reconfig_rom
    import pll_reconfig_pkg::*;
(
    input  logic [ROM_IDX_W-1:0] preset,
    input  logic [ROM_IDX_W-1:0] step,
    output entry_t               entry
);

    always_comb entry = preset_entry(preset, step);

endmodule

// File: rtl/pll_reconfig_seq.sv
// Streams a stored preset into the PLL reconfig controller over Avalon-MM,
// starts reconfiguration and waits for a stable re-lock.
module pll_reconfig_seq
    import pll_reconfig_pkg::*;
#(
    parameter int NUM_PRESETS  = 2,
    parameter int ENTRIES      = 8,
    parameter int LOCK_STABLE  = 16,
    parameter int LOCK_TIMEOUT = 1_000_000,
    localparam int PW = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    input  logic [PW-1:0] req_preset,
    output logic          req_ready,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          lock_lost,
    output logic [5:0]    mgmt_address,
    output logic          mgmt_write,
    output logic [31:0]   mgmt_writedata,
    input  logic          mgmt_waitrequest,
    input  logic          pll_locked
);

    localparam int SW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int LW = $clog2(LOCK_STABLE + 1);

    state_t        state;
    logic [PW-1:0] preset;
    logic [SW-1:0] step;
    logic [SW-1:0] rom_step;
    logic [TW-1:0] timeout_cnt;
    logic [LW-1:0] stable_cnt;
    logic          locked_meta, locked_sync, locked_prev;
    logic          wr_accept;
    entry_t        rom_entry;

    assign wr_accept = mgmt_write & ~mgmt_waitrequest;

    // Look one entry ahead so the next write is ready on the acceptance edge.
    always_comb rom_step = (state == S_WR_REGS) ? step + 1'b1 : '0;

    pll_reconfig_rom u_rom (
        .preset (ROM_IDX_W'(preset)),
        .step   (ROM_IDX_W'(rom_step)),
        .entry  (rom_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
            locked_prev <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_sync <= locked_meta;
            locked_prev <= locked_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            preset         <= '0;
            step           <= '0;
            timeout_cnt    <= '0;
            stable_cnt     <= '0;
            req_ready      <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            lock_lost      <= 1'b0;
            mgmt_write     <= 1'b0;
            mgmt_address   <= '0;
            mgmt_writedata <= '0;
        end else begin
            done      <= 1'b0;
            error     <= 1'b0;
            lock_lost <= (state == S_IDLE) & locked_prev & ~locked_sync;
            case (state)
                S_IDLE: if (req_valid) begin
                    req_ready <= 1'b0;
                    busy      <= 1'b1;
                    if (32'(req_preset) >= NUM_PRESETS) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end else begin
                        preset         <= req_preset;
                        step           <= '0;
                        state          <= S_WR_MODE;
                        mgmt_write     <= 1'b1;
                        mgmt_address   <= ADDR_MODE;
                        mgmt_writedata <= 32'd0;
                    end
                end
                S_WR_MODE: if (wr_accept) begin
                    mgmt_address   <= rom_entry.addr;
                    mgmt_writedata <= rom_entry.data;
                    state          <= S_WR_REGS;
                end
                S_WR_REGS: if (wr_accept) begin
                    if (step == SW'(ENTRIES - 1)) begin
                        mgmt_address   <= ADDR_START;
                        mgmt_writedata <= 32'd1;
                        state          <= S_WR_START;
                    end else begin
                        step           <= step + 1'b1;
                        mgmt_address   <= rom_entry.addr;
                        mgmt_writedata <= rom_entry.data;
                    end
                end
                S_WR_START: if (wr_accept) begin
                    mgmt_write     <= 1'b0;
                    mgmt_address   <= '0;
                    mgmt_writedata <= '0;
                    timeout_cnt    <= '0;
                    stable_cnt     <= '0;
                    state          <= S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    timeout_cnt <= timeout_cnt + 1'b1;
                    stable_cnt  <= locked_sync ? stable_cnt + 1'b1 : '0;
                    // Stability is tested first so it wins a same-cycle tie with timeout.
                    if (locked_sync && stable_cnt == LW'(LOCK_STABLE - 1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (timeout_cnt == TW'(LOCK_TIMEOUT - 1)) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end
                end
                S_DONE, S_ERROR: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq: bus writes are scoreboarded against
// hand-written preset tables, lock/timeout latencies are counted in cycles.
module tb_pll_reconfig_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [1:0]  req_preset;
    logic        req_ready, busy, done, error, lock_lost;
    logic [5:0]  mgmt_address;
    logic        mgmt_write;
    logic [31:0] mgmt_writedata;
    logic        mgmt_waitrequest;
    logic        pll_locked;

    int checks = 0, passed = 0;
    int n_done = 0, n_err = 0, n_lost = 0, n_acc = 0;
    int wr_idx = 0, stall_idx = -1, stall_left = 0;
    bit stalled = 1'b0;
    logic [37:0] hold;
    logic [37:0] sb[$];

    always #5 clk = ~clk;

    pll_reconfig_seq #(
        .NUM_PRESETS(3), .ENTRIES(8), .LOCK_STABLE(16), .LOCK_TIMEOUT(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_preset(req_preset),
        .req_ready(req_ready), .busy(busy), .done(done), .error(error),
        .lock_lost(lock_lost), .mgmt_address(mgmt_address), .mgmt_write(mgmt_write),
        .mgmt_writedata(mgmt_writedata), .mgmt_waitrequest(mgmt_waitrequest),
        .pll_locked(pll_locked)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [37:0] rom_exp(input int p, input int i);
        logic [31:0] t0 [8];
        logic [31:0] t1 [8];
        logic [5:0]  a  [8];
        a  = '{6'd3, 6'd4, 6'd7, 6'd5, 6'd5, 6'd5, 6'd5, 6'd5};
        t0 = '{32'h0000_0101, 32'h0000_0606, 32'h0000_0000, 32'h0000_0202,
               32'h0004_0303, 32'h0008_0404, 32'h000C_0505, 32'h0010_0606};
        t1 = '{32'h0000_0101, 32'h0000_0707, 32'h1000_0000, 32'h0000_0303,
               32'h0004_0404, 32'h0008_0505, 32'h000C_0606, 32'h0010_0707};
        return {a[i], (p == 0) ? t0[i] : t1[i]};
    endfunction

    task automatic push_expected(input int p);
        sb.push_back({6'd0, 32'd0});
        for (int i = 0; i < 8; i++) sb.push_back(rom_exp(p, i));
        sb.push_back({6'd2, 32'd1});
    endtask

    // One cycle: advance to the falling edge, then act as the reconfig slave.
    task automatic tick();
        logic [37:0] e;
        @(negedge clk);
        if (done) n_done++;
        if (error) n_err++;
        if (lock_lost) n_lost++;
        if (!busy) begin
            wr_idx = 0;
            stalled = 1'b0;
            mgmt_waitrequest = 1'b0;
        end
        if (rst_n && mgmt_write) begin
            if (stall_left == 0 && wr_idx == stall_idx && !stalled) begin
                stalled = 1'b1;
                stall_left = 5;
                hold = {mgmt_address, mgmt_writedata};
                mgmt_waitrequest = 1'b1;
            end else begin
                if (stall_left > 0) begin
                    chk("stall_hold", {mgmt_address, mgmt_writedata}, hold);
                    stall_left--;
                end
                if (stall_left == 0) begin
                    mgmt_waitrequest = 1'b0;
                    chk("sb_nonempty", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        chk("write", {mgmt_address, mgmt_writedata}, e);
                    end
                    wr_idx++;
                    n_acc++;
                end
            end
        end
    endtask

    task automatic request(input logic [1:0] p, input int exp_burst);
        int n;
        req_valid = 1'b1;
        req_preset = p;
        chk("req_ready_pre", req_ready, 1);
        if (p < 2) push_expected(p);
        tick();
        req_valid = 1'b0;
        chk("busy_n1", busy, 1);
        chk("req_ready_n1", req_ready, 0);
        chk("write_n1", mgmt_write, (p < 2) ? 1 : 0);
        n = 0;
        while (mgmt_write && n < 64) begin
            n++;
            tick();
        end
        chk("burst_len", n, exp_burst);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 40);
        chk(tag, k, 18);
    endtask

    initial begin
        int k, acc0;
        rst_n = 1'b0; req_valid = 1'b0; req_preset = '0;
        mgmt_waitrequest = 1'b0; pll_locked = 1'b1;
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_outs", {busy, done, error, lock_lost, mgmt_write}, 5'b0);
        chk("rst_bus", {mgmt_address, mgmt_writedata}, 38'h0);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        chk("no_lost_after_rst", n_lost, 0);
        chk("idle_ready", req_ready, 1);
        pll_locked = 1'b0;
        repeat (6) tick();
        chk("lock_lost_pulse", n_lost, 1);

        // Preset 0, zero-wait burst; a request while busy must be ignored.
        request(2'd0, 10);
        chk("sb_empty_p0", sb.size(), 0);
        req_valid = 1'b1; req_preset = 2'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("ready_low_busy", req_ready, 0);
        end
        req_valid = 1'b0;
        repeat (16) tick();
        chk("no_done_unlocked", n_done, 0);
        pll_locked = 1'b1;
        wait_done("lock_latency");
        tick();
        chk("ready_after_done", {req_ready, busy, done}, 3'b100);
        chk("done_count", n_done, 1);
        chk("acc_p0", n_acc, 10);

        // Preset 1 with a 5-cycle stall on ROM entry 3, then a lock glitch.
        pll_locked = 1'b0;
        repeat (6) tick();
        stall_idx = 4;
        request(2'd1, 15);
        stall_idx = -1;
        chk("sb_empty_p1", sb.size(), 0);
        pll_locked = 1'b1;
        repeat (12) tick();
        pll_locked = 1'b0;
        repeat (3) tick();
        pll_locked = 1'b1;
        wait_done("relock_latency");
        chk("done_count2", n_done, 2);

        // Lock never returns: timeout error.
        pll_locked = 1'b0;
        repeat (6) tick();
        request(2'd0, 10);
        k = 0;
        do begin
            tick();
            k++;
        end while (!error && k < 1100);
        chk("timeout_latency", k, 1000);
        chk("no_done_timeout", n_done, 2);
        tick();
        chk("ready_after_err", {req_ready, error}, 2'b10);

        // Out-of-range preset: immediate error, no bus traffic.
        acc0 = n_acc;
        request(2'd3, 0);
        chk("bad_idx_error", error, 1);
        tick();
        chk("bad_idx_ready", {req_ready, error}, 2'b10);
        chk("bad_idx_nowrites", n_acc, acc0);
        chk("err_count", n_err, 2);

        // Asynchronous reset in the middle of the ROM writes.
        req_valid = 1'b1; req_preset = 2'd0;
        push_expected(0);
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_write", mgmt_write, 0);
        chk("async_rst_state", {req_ready, busy, mgmt_address}, {1'b1, 1'b0, 6'd0});
        sb.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", {req_ready, busy, mgmt_write}, 3'b100);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
